// File: rtl/alu_opnd_stage_pkg.sv
// Shared operand-mode encodings and default widths for the ID/EX operand stage.
package alu_opnd_stage_pkg;

    localparam int unsigned ALU_SRC_WIDTH  = 3;
    localparam int unsigned CPU_WIDTH      = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned STALL_CNT_W    = 16;

    typedef enum logic [ALU_SRC_WIDTH-1:0] {
        ALU_SRC_REG      = 3'd0,
        ALU_SRC_IMM      = 3'd1,
        ALU_SRC_FOUR_PC  = 3'd2,
        ALU_SRC_IMM_PC   = 3'd3,
        ALU_SRC_ZERO_IMM = 3'd4
    } alu_src_e;

endpackage

// File: rtl/alu_opnd_stage_fwd_sel.sv
// Per-operand priority forwarding mux with load-use detection; lowest source index wins.
module alu_opnd_stage_fwd_sel #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned FWD_N  = 2
) (
    input  logic [REG_AW-1:0]       rs_addr,
    input  logic [DATA_W-1:0]       rf_data,
    input  logic                    opnd_use,
    input  logic [FWD_N-1:0]        fwd_valid,
    input  logic [FWD_N-1:0]        fwd_pending,
    input  logic [FWD_N*REG_AW-1:0] fwd_addr,
    input  logic [FWD_N*DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0]       opnd_data_c,
    output logic                    opnd_hazard_c
);

    logic hit_c;

    // x0 and unused operands never match, so they fall through to regfile data
    always_comb begin
        hit_c         = 1'b0;
        opnd_data_c   = rf_data;
        opnd_hazard_c = 1'b0;
        for (int unsigned i = 0; i < FWD_N; i++) begin
            if (!hit_c && opnd_use && (rs_addr != '0) && fwd_valid[i] &&
                (fwd_addr[i*REG_AW +: REG_AW] == rs_addr)) begin
                hit_c         = 1'b1;
                opnd_data_c   = fwd_data[i*DATA_W +: DATA_W];
                opnd_hazard_c = fwd_pending[i];
            end
        end
    end

endmodule

// File: rtl/alu_opnd_stage.sv
// ID/EX operand stage: operand select, forwarding, load-use stall and registered handshake.
// Optional hazard-cycle counter enabled by defining OPND_STALL_CNT_EN.
module alu_opnd_stage
    import alu_opnd_stage_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_WIDTH,
    parameter int unsigned REG_AW = REG_ADDR_WIDTH,
    parameter int unsigned FWD_N  = 2,
    parameter int unsigned PC_INC = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ALU_SRC_WIDTH-1:0] alu_src_sel,
    input  logic [REG_AW-1:0]        rs1_addr,
    input  logic [REG_AW-1:0]        rs2_addr,
    input  logic [DATA_W-1:0]        reg1_rdata,
    input  logic [DATA_W-1:0]        reg2_rdata,
    input  logic [DATA_W-1:0]        imm,
    input  logic [DATA_W-1:0]        curr_pc,
    input  logic [FWD_N-1:0]         fwd_valid,
    input  logic [FWD_N-1:0]         fwd_pending,
    input  logic [FWD_N*REG_AW-1:0]  fwd_addr,
    input  logic [FWD_N*DATA_W-1:0]  fwd_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        alu_src1,
    output logic [DATA_W-1:0]        alu_src2,
    output logic                     hazard,
    output logic [STALL_CNT_W-1:0]   stall_cnt
);

    logic              use1_c, use2_c;
    logic              hz1_c, hz2_c, hazard_c, ready_c, accept_c;
    logic [DATA_W-1:0] r1_c, r2_c;
    logic [DATA_W-1:0] src1_d, src1_q, src2_d, src2_q;
    logic              out_valid_d, out_valid_q;

    // Which register operands the mode actually consumes (codes 5-7 alias REG)
    always_comb begin
        use1_c = 1'b1;
        use2_c = 1'b1;
        case (alu_src_e'(alu_src_sel))
            ALU_SRC_IMM:      use2_c = 1'b0;
            ALU_SRC_FOUR_PC,
            ALU_SRC_IMM_PC,
            ALU_SRC_ZERO_IMM: begin
                use1_c = 1'b0;
                use2_c = 1'b0;
            end
            default: ;
        endcase
    end

    alu_opnd_stage_fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_N(FWD_N)) u_fwd1 (
        .rs_addr       (rs1_addr),
        .rf_data       (reg1_rdata),
        .opnd_use      (use1_c),
        .fwd_valid     (fwd_valid),
        .fwd_pending   (fwd_pending),
        .fwd_addr      (fwd_addr),
        .fwd_data      (fwd_data),
        .opnd_data_c   (r1_c),
        .opnd_hazard_c (hz1_c)
    );

    alu_opnd_stage_fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_N(FWD_N)) u_fwd2 (
        .rs_addr       (rs2_addr),
        .rf_data       (reg2_rdata),
        .opnd_use      (use2_c),
        .fwd_valid     (fwd_valid),
        .fwd_pending   (fwd_pending),
        .fwd_addr      (fwd_addr),
        .fwd_data      (fwd_data),
        .opnd_data_c   (r2_c),
        .opnd_hazard_c (hz2_c)
    );

    always_comb begin
        src1_d = r1_c;
        src2_d = r2_c;
        case (alu_src_e'(alu_src_sel))
            ALU_SRC_IMM:      src2_d = imm;
            ALU_SRC_FOUR_PC: begin
                src1_d = DATA_W'(PC_INC);
                src2_d = curr_pc;
            end
            ALU_SRC_IMM_PC: begin
                src1_d = imm;
                src2_d = curr_pc;
            end
            ALU_SRC_ZERO_IMM: begin
                src1_d = '0;
                src2_d = imm;
            end
            default: ;
        endcase
    end

    assign hazard_c = in_valid & (hz1_c | hz2_c);
    assign ready_c  = ~hazard_c & ~flush & (~out_valid_q | out_ready);
    assign accept_c = in_valid & ready_c;

    // Flush beats accept; an unconsumed entry holds, a consumed one drains
    always_comb begin
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_c) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept_c) begin
                src1_q <= src1_d;
                src2_q <= src2_d;
            end
        end
    end

`ifdef OPND_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    // Saturating count of load-use stall cycles; survives flush
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard_c && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

    assign in_ready  = ready_c;
    assign hazard    = hazard_c;
    assign out_valid = out_valid_q;
    assign alu_src1  = src1_q;
    assign alu_src2  = src2_q;

endmodule

// File: tb/tb_alu_opnd_stage.sv
// Scoreboard bench for alu_opnd_stage: directed plan items plus randomized traffic.
module tb_alu_opnd_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned FWD_N  = 2;
    localparam int unsigned PC_INC = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              alu_src_sel;
    logic [REG_AW-1:0]       rs1_addr, rs2_addr;
    logic [DATA_W-1:0]       reg1_rdata, reg2_rdata, imm, curr_pc;
    logic [FWD_N-1:0]        fwd_valid, fwd_pending;
    logic [FWD_N*REG_AW-1:0] fwd_addr;
    logic [FWD_N*DATA_W-1:0] fwd_data;
    logic                    flush;
    logic                    out_valid, out_ready;
    logic [DATA_W-1:0]       alu_src1, alu_src2;
    logic                    hazard;
    logic [15:0]             stall_cnt;

    always #5 clk = ~clk;

    alu_opnd_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_N(FWD_N), .PC_INC(PC_INC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_src_sel (alu_src_sel),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .reg1_rdata  (reg1_rdata),
        .reg2_rdata  (reg2_rdata),
        .imm         (imm),
        .curr_pc     (curr_pc),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_src1    (alu_src1),
        .alu_src2    (alu_src2),
        .hazard      (hazard),
        .stall_cnt   (stall_cnt)
    );

    typedef struct {
        logic [DATA_W-1:0] s1;
        logic [DATA_W-1:0] s2;
    } exp_t;

    exp_t              q[$];
    logic              fv[FWD_N];
    logic              fp[FWD_N];
    logic [REG_AW-1:0] fa[FWD_N];
    logic [DATA_W-1:0] fd[FWD_N];
    logic              m_valid;
    logic [15:0]       m_cnt;
    int unsigned       n_vec = 0;
    int unsigned       n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference forwarding: scan oldest to youngest so the youngest match is what remains
    task automatic ref_opnd(input logic [REG_AW-1:0] rs, input logic [DATA_W-1:0] rf,
                            output logic [DATA_W-1:0] d, output logic pend);
        d    = rf;
        pend = 1'b0;
        if (rs != 0) begin
            for (int i = FWD_N - 1; i >= 0; i--) begin
                if (fv[i] && fa[i] == rs) begin
                    d    = fd[i];
                    pend = fp[i];
                end
            end
        end
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        alu_src_sel = 3'd0;
        rs1_addr    = '0;
        rs2_addr    = '0;
        reg1_rdata  = '0;
        reg2_rdata  = '0;
        imm         = '0;
        curr_pc     = '0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        for (int i = 0; i < FWD_N; i++) begin
            fv[i] = 1'b0;
            fp[i] = 1'b0;
            fa[i] = '0;
            fd[i] = '0;
        end
    endtask

    // Apply current inputs, check comb outputs against the model, then advance one cycle
    task automatic step();
        logic [DATA_W-1:0] a1, a2, s1, s2;
        logic              p1, p2, u1, u2, ehz, erdy, acc;
        for (int i = 0; i < FWD_N; i++) begin
            fwd_valid[i]                 = fv[i];
            fwd_pending[i]               = fp[i];
            fwd_addr[i*REG_AW +: REG_AW] = fa[i];
            fwd_data[i*DATA_W +: DATA_W] = fd[i];
        end
        #1;
        ref_opnd(rs1_addr, reg1_rdata, a1, p1);
        ref_opnd(rs2_addr, reg2_rdata, a2, p2);
        u1 = !(alu_src_sel inside {3'd2, 3'd3, 3'd4});
        u2 = !(alu_src_sel inside {3'd1, 3'd2, 3'd3, 3'd4});
        case (alu_src_sel)
            3'd1:    begin s1 = a1;                s2 = imm;     end
            3'd2:    begin s1 = 32'(PC_INC);       s2 = curr_pc; end
            3'd3:    begin s1 = imm;               s2 = curr_pc; end
            3'd4:    begin s1 = '0;                s2 = imm;     end
            default: begin s1 = a1;                s2 = a2;      end
        endcase
        ehz  = in_valid && ((u1 && p1) || (u2 && p2));
        erdy = !ehz && !flush && (!m_valid || out_ready);
        acc  = in_valid && erdy;
        chk("hazard", 32'(hazard), 32'(ehz));
        chk("in_ready", 32'(in_ready), 32'(erdy));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        if (flush) q.delete();
        if (acc) q.push_back('{s1, s2});
`ifdef OPND_STALL_CNT_EN
        if (ehz && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
        m_valid = flush ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : m_valid;
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input logic [2:0] mode, input logic [REG_AW-1:0] r1a,
                          input logic [REG_AW-1:0] r2a, input logic [DATA_W-1:0] r1,
                          input logic [DATA_W-1:0] r2, input logic [DATA_W-1:0] im,
                          input logic [DATA_W-1:0] pc);
        in_valid    = 1'b1;
        alu_src_sel = mode;
        rs1_addr    = r1a;
        rs2_addr    = r2a;
        reg1_rdata  = r1;
        reg2_rdata  = r2;
        imm         = im;
        curr_pc     = pc;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_src1"}, alu_src1, 32'd0);
        chk({tag, "_src2"}, alu_src2, 32'd0);
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
    endtask

    // Monitor: the held entry is consumed at the next edge when out_valid & out_ready
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: src1=0x%0h src2=0x%0h with empty scoreboard",
                         alu_src1, alu_src2);
            end else begin
                e = q.pop_front();
                chk("alu_src1", alu_src1, e.s1);
                chk("alu_src2", alu_src2, e.s2);
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        m_valid = 1'b0;
        m_cnt   = '0;
        idle();
        #12;
        check_reset_state("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Plain register operands
        set_op(3'd0, 5'd1, 5'd2, 32'h11, 32'h22, 32'h0, 32'h0);
        step();
        idle();
        step();

        // PC-relative and zero/immediate modes
        set_op(3'd2, 5'd1, 5'd2, 32'h55, 32'h66, 32'h0, 32'h80);
        step();
        set_op(3'd4, 5'd1, 5'd2, 32'h55, 32'h66, 32'hABC, 32'h80);
        step();
        set_op(3'd3, 5'd3, 5'd4, 32'h55, 32'h66, 32'h123, 32'h200);
        step();
        idle();
        step();

        // Both sources match rs1: youngest wins; x0 never forwards
        fv[0] = 1'b1; fa[0] = 5'd5; fd[0] = 32'hA0;
        fv[1] = 1'b1; fa[1] = 5'd5; fd[1] = 32'hB0;
        set_op(3'd0, 5'd5, 5'd3, 32'h99, 32'h33, 32'h0, 32'h0);
        step();
        fa[0] = 5'd0; fa[1] = 5'd0;
        set_op(3'd0, 5'd0, 5'd3, 32'h99, 32'h33, 32'h0, 32'h0);
        step();
        idle();
        step();

        // Load-use on rs2 for two cycles, then forwarded data arrives
        fv[0] = 1'b1; fa[0] = 5'd7; fd[0] = 32'h77; fp[0] = 1'b1;
        set_op(3'd0, 5'd1, 5'd7, 32'h10, 32'h20, 32'h0, 32'h0);
        step();
        step();
        fp[0] = 1'b0;
        step();
        fp[0] = 1'b1;
        set_op(3'd1, 5'd1, 5'd7, 32'h10, 32'h20, 32'h44, 32'h0);
        step();
        // Pending older entry shadowed by a younger ready one
        fv[1] = 1'b1; fa[1] = 5'd7; fd[1] = 32'h88; fp[1] = 1'b1; fp[0] = 1'b0;
        set_op(3'd0, 5'd1, 5'd7, 32'h10, 32'h20, 32'h0, 32'h0);
        step();
        idle();
        step();

        // Backpressure hold, then back-to-back reload
        set_op(3'd0, 5'd1, 5'd2, 32'hC1, 32'hC2, 32'h0, 32'h0);
        out_ready = 1'b0;
        step();
        set_op(3'd1, 5'd1, 5'd2, 32'hD1, 32'hD2, 32'hD3, 32'h0);
        step();
        step();
        out_ready = 1'b1;
        step();
        set_op(3'd0, 5'd3, 5'd4, 32'hE1, 32'hE2, 32'h0, 32'h0);
        step();
        idle();
        step();

        // Flush with a held entry and a new instruction present
        set_op(3'd0, 5'd1, 5'd2, 32'hF1, 32'hF2, 32'h0, 32'h0);
        out_ready = 1'b0;
        step();
        flush = 1'b1;
        set_op(3'd0, 5'd1, 5'd2, 32'hF3, 32'hF4, 32'h0, 32'h0);
        step();
        flush     = 1'b0;
        out_ready = 1'b1;
        step();
        idle();
        step();

        // Randomized traffic with an asynchronous reset in the middle
        for (int n = 0; n < 600; n++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            alu_src_sel = 3'($urandom_range(0, 7));
            rs1_addr    = 5'($urandom_range(0, 7));
            rs2_addr    = 5'($urandom_range(0, 7));
            reg1_rdata  = $urandom;
            reg2_rdata  = $urandom;
            imm         = $urandom;
            curr_pc     = $urandom;
            for (int i = 0; i < FWD_N; i++) begin
                fv[i] = ($urandom_range(0, 1) != 0);
                fp[i] = ($urandom_range(0, 4) == 0);
                fa[i] = 5'($urandom_range(0, 7));
                fd[i] = $urandom;
            end
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = flush ? 1'b0 : ($urandom_range(0, 9) < 7);
            step();
            if (n == 300) begin
                #5;
                rst_n    = 1'b0;
                in_valid = 1'b0;
                #1;
                check_reset_state("async_reset");
                q.delete();
                m_valid = 1'b0;
                m_cnt   = '0;
                @(posedge clk);
                @(posedge clk);
                #2;
                rst_n = 1'b1;
            end
        end

        idle();
        repeat (3) step();
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
